// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding, default geometry and address-field widths for the data cache
package cache_pkg;

  localparam int DEFAULT_LINES       = 32;
  localparam int DEFAULT_BLOCK_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } cacheState_t;

  function automatic int offsetBits(input int blockWords);
    return $clog2(blockWords);
  endfunction

  function automatic int indexBits(input int lines);
    return $clog2(lines);
  endfunction

  // Two byte-offset bits are dropped since only word accesses exist.
  function automatic int tagBits(input int lines, input int blockWords);
    return 32 - 2 - $clog2(lines) - $clog2(blockWords);
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - word-wide ready-handshaked memory port between the cache and main memory
interface data_cache_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/cache_array.sv
// rtl/cache_array.sv - tag, valid and data storage: one combinational read port, one word-write port
module cache_array
  import cache_pkg::*;
#(
  parameter int  LINES       = DEFAULT_LINES,
  parameter int  BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
  localparam int IW          = indexBits(LINES),
  localparam int OW          = offsetBits(BLOCK_WORDS),
  localparam int TW          = tagBits(LINES, BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rdIndex,
  input  logic [OW-1:0] rdOffset,
  output logic          rdValid,
  output logic [TW-1:0] rdTag,
  output logic [31:0]   rdWord,
  input  logic          wordWe,
  input  logic          tagWe,
  input  logic [IW-1:0] wrIndex,
  input  logic [OW-1:0] wrOffset,
  input  logic [31:0]   wrWord,
  input  logic [TW-1:0] wrTag
);

  logic [31:0]    dataMem [LINES][BLOCK_WORDS];
  logic [TW-1:0]  tagMem  [LINES];
  logic [LINES-1:0] valid;

  assign rdValid = valid[rdIndex];
  assign rdTag   = tagMem[rdIndex];
  assign rdWord  = dataMem[rdIndex][rdOffset];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (tagWe) begin
      valid[wrIndex] <= 1'b1;
    end
  end

  // Payload storage is deliberately left unreset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (wordWe) dataMem[wrIndex][wrOffset] <= wrWord;
    if (tagWe)  tagMem[wrIndex] <= wrTag;
  end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache for the core M stage
module data_cache
  import cache_pkg::*;
#(
  parameter int LINES       = DEFAULT_LINES,
  parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MemReadM,
  input  logic         MemWriteM,
  input  logic [31:0]  ALUoutM,
  input  logic [31:0]  RD2_Reg_File_aft_muxM,
  output logic [31:0]  Mem_RDM,
  output logic         Mem_Stall,
  data_cache_if.master mem
);

  localparam int IW = indexBits(LINES);
  localparam int OW = offsetBits(BLOCK_WORDS);
  localparam int TW = tagBits(LINES, BLOCK_WORDS);
  localparam int IDX_LO = OW + 2;
  localparam logic [OW-1:0] LAST_WORD = OW'(BLOCK_WORDS - 1);

  cacheState_t   state;
  logic [OW-1:0] counter;
  logic [29:0]   reqWord;
  logic [31:0]   reqData;

  logic [29:0]   lookupWord;
  logic          rdValid;
  logic [TW-1:0] rdTag;
  logic [31:0]   rdWord;
  logic          hit;
  logic          lastBeat;

  // In IDLE the core address is looked up; otherwise the latched request is.
  assign lookupWord = (state == IDLE) ? ALUoutM[31:2] : reqWord;
  assign hit        = rdValid && (rdTag == lookupWord[29:OW+IW]);
  assign lastBeat   = (state == REFILL) && mem.mem_ready && (counter == LAST_WORD);

  cache_array #(.LINES(LINES), .BLOCK_WORDS(BLOCK_WORDS)) u_array (
    .clk      (clk),
    .rst      (rst),
    .rdIndex  (lookupWord[OW+IW-1:OW]),
    .rdOffset (lookupWord[OW-1:0]),
    .rdValid  (rdValid),
    .rdTag    (rdTag),
    .rdWord   (rdWord),
    .wordWe   (((state == REFILL) || ((state == WRITE) && hit)) && mem.mem_ready),
    .tagWe    (lastBeat),
    .wrIndex  (reqWord[OW+IW-1:OW]),
    .wrOffset ((state == REFILL) ? counter : reqWord[OW-1:0]),
    .wrWord   ((state == REFILL) ? mem.mem_rdata : reqData),
    .wrTag    (reqWord[29:OW+IW])
  );

  always_comb begin
    Mem_Stall = 1'b0;
    Mem_RDM   = '0;
    case (state)
      IDLE: begin
        if (MemWriteM) begin
          Mem_Stall = 1'b1;
        end else if (MemReadM) begin
          if (hit) Mem_RDM = rdWord;
          else     Mem_Stall = 1'b1;
        end
      end
      REFILL:  Mem_Stall = 1'b1;
      WRITE:   Mem_Stall = ~mem.mem_ready;
      default: Mem_Stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      counter       <= '0;
      reqWord       <= '0;
      reqData       <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWriteM) begin
            reqWord       <= ALUoutM[31:2];
            reqData       <= RD2_Reg_File_aft_muxM;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= ALUoutM & ~32'h3;
            mem.mem_wdata <= RD2_Reg_File_aft_muxM;
            state         <= WRITE;
          end else if (MemReadM && !hit) begin
            reqWord      <= {ALUoutM[31:IDX_LO], {OW{1'b0}}};
            counter      <= '0;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= {ALUoutM[31:IDX_LO], {IDX_LO{1'b0}}};
            state        <= REFILL;
          end
        end
        REFILL: begin
          if (mem.mem_ready) begin
            counter      <= counter + 1'b1;
            mem.mem_addr <= mem.mem_addr + 32'd4;
            if (counter == LAST_WORD) begin
              mem.mem_req <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed plus randomized bench for data_cache against a flat-memory and tag-table model
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUoutM = '0;
  logic [31:0] RD2_Reg_File_aft_muxM = '0;
  logic [31:0] Mem_RDM;
  logic        Mem_Stall;

  data_cache_if bus ();

  data_cache #(.LINES(32), .BLOCK_WORDS(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .MemReadM              (MemReadM),
    .MemWriteM             (MemWriteM),
    .ALUoutM               (ALUoutM),
    .RD2_Reg_File_aft_muxM (RD2_Reg_File_aft_muxM),
    .Mem_RDM               (Mem_RDM),
    .Mem_Stall             (Mem_Stall),
    .mem                   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] physMem [logic [31:0]];
  logic [31:0] refMem  [logic [31:0]];
  logic [31:0] readLog [$];
  int          readyDelay = 0;
  int          waitCnt = 0;
  int          writeCount = 0;
  int          weCycles = 0;

  bit          mValid [32];
  logic [22:0] mTag   [32];

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  function automatic logic [31:0] physRead(input logic [31:0] a);
    return physMem.exists(a) ? physMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Main-memory responder: accepts a word readyDelay cycles after the request is seen.
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_we) weCycles++;
    if (bus.mem_req && bus.mem_ready) begin
      if (bus.mem_we) begin
        physMem[bus.mem_addr] = bus.mem_wdata;
        writeCount++;
      end else begin
        readLog.push_back(bus.mem_addr);
      end
      waitCnt = 0;
    end else if (bus.mem_req) begin
      waitCnt++;
    end else begin
      waitCnt = 0;
    end
    #1;
    bus.mem_ready = bus.mem_req && (waitCnt >= readyDelay);
    bus.mem_rdata = physRead(bus.mem_addr);
  end

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd, output int stalls);
    bit timedOut = 1'b0;
    MemReadM = !wr;
    MemWriteM = wr;
    ALUoutM = addr;
    RD2_Reg_File_aft_muxM = data;
    stalls = 0;
    rd = '0;
    forever begin
      @(negedge clk);
      if (!Mem_Stall) begin
        rd = Mem_RDM;
        break;
      end
      stalls++;
      if (stalls >= 300) begin
        timedOut = 1'b1;
        break;
      end
    end
    check("bounded_wait", {31'd0, timedOut}, 32'd0);
    @(posedge clk);
    #1;
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
  endtask

  task automatic doOp(input bit wr, input logic [31:0] addr, input logic [31:0] data, input int delay);
    logic [31:0] wa;
    logic [31:0] base;
    logic [31:0] rd;
    int          stalls;
    int          idx;
    bit          hit;
    wa = addr & ~32'h3;
    base = addr & ~32'hF;
    idx = int'(wa[8:4]);
    hit = mValid[idx] && (mTag[idx] == wa[31:9]);
    readyDelay = delay;
    readLog.delete();
    writeCount = 0;
    weCycles = 0;
    access(wr, addr, data, rd, stalls);
    if (wr) begin
      refMem[wa] = data;
      check("store_stall", stalls, 32'(1 + delay));
      check("store_count", writeCount, 32'd1);
      check("store_held", weCycles, 32'(delay + 1));
      check("store_mem", physRead(wa), data);
      check("store_reads", readLog.size(), 32'd0);
    end else begin
      check(hit ? "hit_stall" : "miss_stall", stalls, hit ? 32'd0 : 32'(1 + 4 * (delay + 1)));
      check("load_data", rd, refRead(wa));
      check("refill_reads", readLog.size(), hit ? 32'd0 : 32'd4);
      if (!hit && readLog.size() == 4) begin
        for (int k = 0; k < 4; k++) check("refill_addr", readLog[k], base + 32'(4 * k));
      end
      mValid[idx] = 1'b1;
      mTag[idx] = wa[31:9];
    end
  endtask

  initial begin
    logic [31:0] pool [5];
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 32; i++) begin
      mValid[i] = 1'b0;
      mTag[i] = '0;
    end

    #3;
    check("rst_stall", {31'd0, Mem_Stall}, 32'd0);
    check("rst_rdm", Mem_RDM, 32'd0);
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    #14 rst = 1'b1;
    @(posedge clk);
    #1;

    doOp(1'b0, 32'h0000_0100, 32'd0, 0);
    doOp(1'b0, 32'h0000_0108, 32'd0, 0);
    doOp(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 3);
    doOp(1'b0, 32'h0000_0104, 32'd0, 0);
    doOp(1'b1, 32'h0000_2000, 32'h1234_5678, 0);
    doOp(1'b0, 32'h0000_2000, 32'd0, 1);
    doOp(1'b0, 32'h0000_0100, 32'd0, 0);
    doOp(1'b0, 32'h0000_0300, 32'd0, 0);
    doOp(1'b0, 32'h0000_0100, 32'd0, 2);

    // Abort a refill during its second word, then replay the same load.
    readyDelay = 0;
    readLog.delete();
    MemReadM = 1'b1;
    ALUoutM = 32'h0000_0740;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_req", {31'd0, bus.mem_req}, 32'd0);
    check("abort_we", {31'd0, bus.mem_we}, 32'd0);
    check("abort_addr", bus.mem_addr, 32'd0);
    check("abort_reads", readLog.size(), 32'd1);
    MemReadM = 1'b0;
    #1;
    check("abort_stall", {31'd0, Mem_Stall}, 32'd0);
    check("abort_rdm", Mem_RDM, 32'd0);
    for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    doOp(1'b0, 32'h0000_0740, 32'd0, 0);
    doOp(1'b0, 32'h0000_0100, 32'd0, 0);

    pool[0] = 32'h0000_0100;
    pool[1] = 32'h0000_0300;
    pool[2] = 32'h0000_2000;
    pool[3] = 32'h0000_2110;
    pool[4] = 32'h0000_0510;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = pool[$urandom_range(0, 4)] + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      doOp($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
